// File: rtl/chan_regfile_pkg.sv
// Shared widths, status-byte bit positions and a constant log2 helper for chan_regfile.
package chan_regfile_pkg;

    localparam int unsigned CHAN_W         = 7;
    localparam int unsigned DATA_W         = 8;
    localparam int unsigned STAT_FULL_BIT  = 7;
    localparam int unsigned STAT_EMPTY_BIT = 6;
    localparam int unsigned STAT_OVF_BIT   = 5;
    localparam int unsigned STAT_CNT_W     = 5;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/chan_fifo.sv
// First-word fall-through byte FIFO with synchronous reset and flush.
module chan_fifo
    import chan_regfile_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       dataIn,
    output logic [WIDTH-1:0]       dataOut,
    output logic                   full,
    output logic                   empty,
    output logic [clog2(DEPTH):0]  count
);

    localparam int unsigned PTR_W = clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             doPush;
    logic             doPop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign doPush  = push && !full;
    assign doPop   = pop && !empty;
    assign dataOut = mem[rdPtr];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= dataIn;
        end
    end

endmodule

// File: rtl/chan_regfile.sv
// Channel-addressed register file with a loopback FIFO channel and a FIFO status/flush channel.
module chan_regfile
    import chan_regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS   = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned FIFO_CHAN  = 100,
    parameter int unsigned STAT_CHAN  = 101
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic [CHAN_W-1:0] chanAddr_in,
    input  logic [DATA_W-1:0] h2fData_in,
    input  logic              h2fValid_in,
    output logic              h2fReady_out,
    output logic [DATA_W-1:0] f2hData_out,
    output logic              f2hValid_out,
    input  logic              f2hReady_in,
    output logic [DATA_W-1:0] led_out,
    input  logic [DATA_W-1:0] sw_in
);

    localparam int unsigned CNT_W = clog2(FIFO_DEPTH) + 1;

    if (FIFO_CHAN == STAT_CHAN || FIFO_CHAN < NUM_REGS || STAT_CHAN < NUM_REGS ||
        NUM_REGS < 1 || NUM_REGS > 64 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadParams
        $error("chan_regfile: illegal parameter combination");
    end

    logic [DATA_W-1:0]     regs [NUM_REGS];
    logic                  isFifo;
    logic                  isStat;
    logic                  fifoPush;
    logic                  fifoPop;
    logic                  fifoFlush;
    logic [DATA_W-1:0]     fifoData;
    logic                  fifoFull;
    logic                  fifoEmpty;
    logic [CNT_W-1:0]      fifoCount;
    logic                  overflow;
    logic [STAT_CNT_W-1:0] cntSat;
    logic [DATA_W-1:0]     statusByte;

    assign isFifo    = (chanAddr_in == CHAN_W'(FIFO_CHAN));
    assign isStat    = (chanAddr_in == CHAN_W'(STAT_CHAN));
    assign fifoPush  = isFifo && h2fValid_in;
    assign fifoPop   = isFifo && f2hReady_in;
    assign fifoFlush = isStat && h2fValid_in;
    assign led_out   = regs[0];

    chan_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) uFifo (
        .clk     (clk_in),
        .reset   (reset_in),
        .push    (fifoPush),
        .pop     (fifoPop),
        .flush   (fifoFlush),
        .dataIn  (h2fData_in),
        .dataOut (fifoData),
        .full    (fifoFull),
        .empty   (fifoEmpty),
        .count   (fifoCount)
    );

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                regs[k] <= '0;
            end
        end else if (h2fValid_in) begin
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                if (chanAddr_in == CHAN_W'(k)) begin
                    regs[k] <= h2fData_in;
                end
            end
        end
    end

    // Sticky until reset or a status-channel write.
    always_ff @(posedge clk_in) begin
        if (reset_in || fifoFlush) begin
            overflow <= 1'b0;
        end else if (fifoPush && fifoFull) begin
            overflow <= 1'b1;
        end
    end

    always_comb begin
        cntSat = (32'(fifoCount) >= 32) ? STAT_CNT_W'(31) : STAT_CNT_W'(fifoCount);
        statusByte                   = '0;
        statusByte[STAT_FULL_BIT]    = fifoFull;
        statusByte[STAT_EMPTY_BIT]   = fifoEmpty;
        statusByte[STAT_OVF_BIT]     = overflow;
        statusByte[STAT_CNT_W-1:0]   = cntSat;
    end

    // Unmapped channels default to ready/valid with zero data.
    always_comb begin
        f2hData_out  = '0;
        f2hValid_out = 1'b1;
        h2fReady_out = 1'b1;
        if (isFifo) begin
            f2hData_out  = fifoData;
            f2hValid_out = !fifoEmpty;
            h2fReady_out = !fifoFull;
        end else if (isStat) begin
            f2hData_out = statusByte;
        end else if (chanAddr_in == '0) begin
            f2hData_out = sw_in;
        end else begin
            for (int unsigned k = 1; k < NUM_REGS; k++) begin
                if (chanAddr_in == CHAN_W'(k)) begin
                    f2hData_out = regs[k];
                end
            end
        end
    end

endmodule
